// File: rtl/column_scatter.sv
// Write-side sequencer that scatters a pixel stream round-robin across NUM_COL column buffers.
// Optional sticky error flag for ignored cfg_start requests: define COLUMN_SCATTER_ERR_EN.
module column_scatter #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 6,
  parameter int NUM_COL    = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          cfg_start,
  input  logic [ADDR_WIDTH:0]           cfg_len,
  input  logic                          s_valid,
  input  logic [DATA_WIDTH-1:0]         s_data,
  output logic                          s_ready,
  output logic [NUM_COL-1:0]            wr_req,
  output logic [NUM_COL*DATA_WIDTH-1:0] wr_data,
  output logic                          busy,
  output logic                          done
`ifdef COLUMN_SCATTER_ERR_EN
  ,
  output logic                          err
`endif
);

  localparam int COL_W = $clog2(NUM_COL);
  localparam logic [ADDR_WIDTH:0] MAX_LEN  = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] LEN_ONE  = (ADDR_WIDTH+1)'(1);
  localparam logic [COL_W-1:0]    LAST_COL = COL_W'(NUM_COL - 1);

  typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;

  state_t                        state_q, state_d;
  logic [COL_W-1:0]              col_idx_q, col_idx_d;
  logic [ADDR_WIDTH:0]           word_idx_q, word_idx_d;
  logic [ADDR_WIDTH:0]           len_q, len_d;
  logic [NUM_COL-1:0]            wr_req_q, wr_req_d;
  logic [NUM_COL*DATA_WIDTH-1:0] wr_data_q, wr_data_d;
  logic                          done_q, done_d;
  logic                          len_ok;
  logic                          beat;
  logic                          last_beat;

  assign len_ok    = (cfg_len != '0) && (cfg_len <= MAX_LEN);
  assign beat      = s_valid && (state_q == FILL);
  assign last_beat = beat && (col_idx_q == LAST_COL) && (word_idx_q == len_q - LEN_ONE);

  always_comb begin
    state_d    = state_q;
    col_idx_d  = col_idx_q;
    word_idx_d = word_idx_q;
    len_d      = len_q;
    wr_req_d   = '0;
    wr_data_d  = wr_data_q;
    done_d     = 1'b0;

    case (state_q)
      IDLE: begin
        if (cfg_start && len_ok) begin
          len_d      = cfg_len;
          col_idx_d  = '0;
          word_idx_d = '0;
          state_d    = FILL;
        end
      end
      FILL: begin
        if (beat) begin
          wr_req_d = NUM_COL'(1) << col_idx_q;
          for (int c = 0; c < NUM_COL; c++) begin
            if (col_idx_q == COL_W'(c)) begin
              wr_data_d[c*DATA_WIDTH +: DATA_WIDTH] = s_data;
            end
          end
          // word_idx is one bit wider than the address so a full 2**ADDR_WIDTH pass cannot wrap it
          if (col_idx_q == LAST_COL) begin
            col_idx_d  = '0;
            word_idx_d = word_idx_q + LEN_ONE;
          end else begin
            col_idx_d = col_idx_q + COL_W'(1);
          end
          if (last_beat) begin
            done_d  = 1'b1;
            state_d = DONE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      col_idx_q  <= '0;
      word_idx_q <= '0;
      len_q      <= '0;
      wr_req_q   <= '0;
      wr_data_q  <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      col_idx_q  <= col_idx_d;
      word_idx_q <= word_idx_d;
      len_q      <= len_d;
      wr_req_q   <= wr_req_d;
      wr_data_q  <= wr_data_d;
      done_q     <= done_d;
    end
  end

  assign s_ready = (state_q == FILL);
  assign busy    = (state_q != IDLE);
  assign wr_req  = wr_req_q;
  assign wr_data = wr_data_q;
  assign done    = done_q;

`ifdef COLUMN_SCATTER_ERR_EN
  logic err_q, err_d;

  always_comb begin
    err_d = err_q;
    if (cfg_start && (busy || !len_ok)) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err = err_q;
`endif

endmodule

// File: tb/tb_column_scatter.sv
// Directed self-checking bench for column_scatter: dense, gapped, max-length, illegal-config and reset-abort passes.
// Build with COLUMN_SCATTER_ERR_EN defined to also exercise the sticky err flag.
module tb_column_scatter;

  localparam int DATA_WIDTH = 8;
  localparam int ADDR_WIDTH = 6;
  localparam int NUM_COL    = 4;

  logic                          clk;
  logic                          reset;
  logic                          cfgStart;
  logic [ADDR_WIDTH:0]           cfgLen;
  logic                          sValid;
  logic [DATA_WIDTH-1:0]         sData;
  logic                          sReady;
  logic [NUM_COL-1:0]            wrReq;
  logic [NUM_COL*DATA_WIDTH-1:0] wrData;
  logic                          busy;
  logic                          done;
`ifdef COLUMN_SCATTER_ERR_EN
  logic                          err;
`endif

  int checkCount = 0;
  int errorCount = 0;

  column_scatter #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH),
    .NUM_COL   (NUM_COL)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .cfg_start(cfgStart),
    .cfg_len  (cfgLen),
    .s_valid  (sValid),
    .s_data   (sData),
    .s_ready  (sReady),
    .wr_req   (wrReq),
    .wr_data  (wrData),
    .busy     (busy),
    .done     (done)
`ifdef COLUMN_SCATTER_ERR_EN
    ,
    .err      (err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Advance one clock and settle just past the edge, where outputs are sampled and inputs changed
  task automatic stepClk();
    @(posedge clk);
    #1;
  endtask

  // One fill pass with a bench-side beat model; optionally gapped valid and a cfg_start injected mid-pass
  task automatic applyStimulus(input int len, input bit gaps, input bit midStart, input logic [7:0] base);
    int total;
    int beats;
    int cyc;
    int doneSeen;
    int reqSeen[NUM_COL];
    logic v;
    logic [NUM_COL*DATA_WIDTH-1:0] expLanes;

    total    = NUM_COL * len;
    beats    = 0;
    cyc      = 0;
    doneSeen = 0;
    for (int c = 0; c < NUM_COL; c++) reqSeen[c] = 0;

    cfgLen   = (ADDR_WIDTH+1)'(len);
    cfgStart = 1'b1;
    stepClk();
    cfgStart = 1'b0;
    checkOutput("start_busy", {63'd0, busy}, 64'd1);

    while (beats < total) begin
      v = gaps ? (cyc % 3 == 0) : 1'b1;
      checkOutput("fill_ready", {63'd0, sReady}, 64'd1);
      sValid   = v;
      sData    = 8'(base + beats);
      cfgStart = midStart && (beats == 3);
      cfgLen   = 7'd2;
      stepClk();
      cyc++;
      cfgStart = 1'b0;
      if (v) begin
        checkOutput("wr_req", {60'd0, wrReq}, 64'd1 << (beats % NUM_COL));
        checkOutput("lane", {56'd0, wrData[(beats % NUM_COL)*DATA_WIDTH +: DATA_WIDTH]},
                    {56'd0, 8'(base + beats)});
        checkOutput("done", {63'd0, done}, {63'd0, beats == total - 1});
        beats++;
      end else begin
        checkOutput("gap_wr_req", {60'd0, wrReq}, 64'd0);
        checkOutput("gap_done", {63'd0, done}, 64'd0);
      end
      for (int c = 0; c < NUM_COL; c++) if (wrReq[c]) reqSeen[c]++;
      if (done) doneSeen++;
    end

    sValid = 1'b0;
    checkOutput("end_ready", {63'd0, sReady}, 64'd0);
    checkOutput("end_busy", {63'd0, busy}, 64'd1);
    for (int c = 0; c < NUM_COL; c++) begin
      expLanes[c*DATA_WIDTH +: DATA_WIDTH] = 8'(base + total - NUM_COL + c);
    end
    checkOutput("final_lanes", {32'd0, wrData}, {32'd0, expLanes});
    stepClk();
    checkOutput("idle_busy", {63'd0, busy}, 64'd0);
    checkOutput("idle_done", {63'd0, done}, 64'd0);
    checkOutput("idle_wr_req", {60'd0, wrReq}, 64'd0);
    for (int c = 0; c < NUM_COL; c++) begin
      checkOutput("col_req_count", 64'(reqSeen[c]), 64'(len));
    end
    checkOutput("done_count", 64'(doneSeen), 64'd1);
  endtask

  initial begin
    reset    = 1'b1;
    cfgStart = 1'b0;
    cfgLen   = '0;
    sValid   = 1'b0;
    sData    = '0;
    stepClk();
    stepClk();
    checkOutput("rst_wr_req", {60'd0, wrReq}, 64'd0);
    checkOutput("rst_wr_data", {32'd0, wrData}, 64'd0);
    checkOutput("rst_busy", {63'd0, busy}, 64'd0);
    checkOutput("rst_done", {63'd0, done}, 64'd0);
    checkOutput("rst_ready", {63'd0, sReady}, 64'd0);
`ifdef COLUMN_SCATTER_ERR_EN
    checkOutput("rst_err", {63'd0, err}, 64'd0);
`endif
    reset = 1'b0;
    stepClk();

    $display("[TB] dense pass, len 2");
    applyStimulus(2, 1'b0, 1'b0, 8'h10);
    $display("[TB] gapped pass, len 2");
    applyStimulus(2, 1'b1, 1'b0, 8'h10);
    $display("[TB] max pass, len 64");
    applyStimulus(64, 1'b0, 1'b0, 8'h00);
`ifdef COLUMN_SCATTER_ERR_EN
    checkOutput("err_clean", {63'd0, err}, 64'd0);
`endif

    $display("[TB] illegal lengths then mid-pass cfg_start");
    cfgLen   = 7'd0;
    cfgStart = 1'b1;
    stepClk();
    cfgStart = 1'b0;
    checkOutput("len0_busy", {63'd0, busy}, 64'd0);
    checkOutput("len0_ready", {63'd0, sReady}, 64'd0);
    cfgLen   = 7'd65;
    cfgStart = 1'b1;
    stepClk();
    cfgStart = 1'b0;
    checkOutput("len65_busy", {63'd0, busy}, 64'd0);
    checkOutput("len65_ready", {63'd0, sReady}, 64'd0);
`ifdef COLUMN_SCATTER_ERR_EN
    checkOutput("err_set", {63'd0, err}, 64'd1);
`endif
    applyStimulus(2, 1'b0, 1'b1, 8'h10);
`ifdef COLUMN_SCATTER_ERR_EN
    checkOutput("err_sticky", {63'd0, err}, 64'd1);
`endif

    $display("[TB] reset after 3 beats");
    cfgLen   = 7'd2;
    cfgStart = 1'b1;
    stepClk();
    cfgStart = 1'b0;
    sValid   = 1'b1;
    for (int i = 0; i < 3; i++) begin
      sData = 8'(8'h50 + i);
      stepClk();
    end
    reset = 1'b1;
    stepClk();
    checkOutput("abort_wr_req", {60'd0, wrReq}, 64'd0);
    checkOutput("abort_busy", {63'd0, busy}, 64'd0);
    checkOutput("abort_ready", {63'd0, sReady}, 64'd0);
    checkOutput("abort_done", {63'd0, done}, 64'd0);
    checkOutput("abort_wr_data", {32'd0, wrData}, 64'd0);
`ifdef COLUMN_SCATTER_ERR_EN
    checkOutput("abort_err", {63'd0, err}, 64'd0);
`endif
    reset  = 1'b0;
    sValid = 1'b0;
    stepClk();
    checkOutput("post_abort_done", {63'd0, done}, 64'd0);
    applyStimulus(2, 1'b0, 1'b0, 8'hA0);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
